// File: rtl/xilly_loopback_fifo_if.sv
// xilly_loopback_fifo_if: Xillybus 32-bit host-write / host-read stream pair
interface xilly_loopback_fifo_if;
   logic        user_w_write_32_wren;
   logic [31:0] user_w_write_32_data;
   logic        user_w_write_32_full;
   logic        user_w_write_32_open;
   logic        user_r_read_32_rden;
   logic [31:0] user_r_read_32_data;
   logic        user_r_read_32_empty;
   logic        user_r_read_32_open;
   modport master (
      output user_w_write_32_wren, user_w_write_32_data, user_w_write_32_open,
      output user_r_read_32_rden, user_r_read_32_open,
      input  user_w_write_32_full, user_r_read_32_data, user_r_read_32_empty
   );
   modport slave (
      input  user_w_write_32_wren, user_w_write_32_data, user_w_write_32_open,
      input  user_r_read_32_rden, user_r_read_32_open,
      output user_w_write_32_full, user_r_read_32_data, user_r_read_32_empty
   );
endinterface

// File: rtl/xilly_loopback_fifo.sv
// xilly_loopback_fifo: non-FWFT loopback FIFO with open/close flush; XILLY_FIFO_STATS_EN adds overflow/underflow counters
module xilly_loopback_fifo #(
   parameter int ADDR_W = 9
) (
   input  logic        bus_clk,
   input  logic        quiesce,
`ifdef XILLY_FIFO_STATS_EN
   output logic [15:0] stat_overflow,
   output logic [15:0] stat_underflow,
`endif
   xilly_loopback_fifo_if.slave bus_if
);
   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
   logic [31:0]       mem [0:(1<<ADDR_W)-1];
   logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [ADDR_W:0]   count_q, count_d;
   logic              full_q, empty_q;
   logic [31:0]       data_q;
   logic              wr_acc, rd_acc, flush;
   // accept decisions use registered flags, so a write into an empty FIFO is never bypassed to a same-cycle read
   always_comb begin
      wr_acc  = ~quiesce & bus_if.user_w_write_32_wren & bus_if.user_w_write_32_open & ~full_q;
      rd_acc  = ~quiesce & bus_if.user_r_read_32_rden & bus_if.user_r_read_32_open & ~empty_q;
      flush   = ~bus_if.user_w_write_32_open & ~bus_if.user_r_read_32_open;
      count_d = flush ? '0 : count_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
   end
   // storage array kept reset-free so it maps onto block RAM
   always_ff @(posedge bus_clk)
      if (wr_acc) mem[wr_ptr_q] <= bus_if.user_w_write_32_data;
   // pointers, occupancy, flags and read register; flush clears state but holds the last read word
   always_ff @(posedge bus_clk)
      if (quiesce) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         data_q   <= '0;
      end else begin
         wr_ptr_q <= flush ? '0 : wr_ptr_q + ADDR_W'(wr_acc);
         rd_ptr_q <= flush ? '0 : rd_ptr_q + ADDR_W'(rd_acc);
         count_q  <= count_d;
         full_q   <= count_d == DEPTH;
         empty_q  <= count_d == '0;
         if (rd_acc) data_q <= mem[rd_ptr_q];
      end
   assign bus_if.user_w_write_32_full  = full_q;
   assign bus_if.user_r_read_32_empty  = empty_q;
   assign bus_if.user_r_read_32_data   = data_q;
`ifdef XILLY_FIFO_STATS_EN
   logic [15:0] ovf_q, unf_q;
   // saturating rejected-strobe counters; only reset clears them
   always_ff @(posedge bus_clk)
      if (quiesce) begin
         ovf_q <= '0;
         unf_q <= '0;
      end else begin
         if (bus_if.user_w_write_32_wren & bus_if.user_w_write_32_open & full_q & (ovf_q != 16'hFFFF)) ovf_q <= ovf_q + 16'd1;
         if (bus_if.user_r_read_32_rden & bus_if.user_r_read_32_open & empty_q & (unf_q != 16'hFFFF)) unf_q <= unf_q + 16'd1;
      end
   assign stat_overflow  = ovf_q;
   assign stat_underflow = unf_q;
`endif
endmodule
